// File: rtl/hart_state_ctrl_pkg.sv
// Hart state table unit: shared types, widths and helpers.
// Imported by the interface, the election logic and the top.
package hart_state_ctrl_pkg;

  localparam int HART_NUM     = 4;
  localparam int HART_ID_B    = 2;
  localparam int HART_STATE_B = HART_NUM;
  localparam int HART_ST_W    = 2;

  typedef enum logic [HART_ST_W-1:0] {
    HART_ST_IDLE    = 2'd0,
    HART_ST_ACTIVE  = 2'd1,
    HART_ST_WAIT_IC = 2'd2,
    HART_ST_WAIT_DC = 2'd3
  } hart_st_e;

  typedef struct packed {
    logic                 valid;
    logic [HART_ID_B-1:0] hid;
  } miss_own_t;

  function automatic logic [2:0] popcnt4(
    input logic [HART_STATE_B-1:0] v
  );
    return {2'b0, v[0]} + {2'b0, v[1]}
         + {2'b0, v[2]} + {2'b0, v[3]};
  endfunction

endpackage

// File: rtl/hart_state_ctrl_if.sv
// ID-stage / cache event inputs and hart state outputs of the hstu.
// master = event sources and consumers, slave = hstu.
interface hart_state_ctrl_if;
  import hart_state_ctrl_pkg::*;

  logic                    id_hstart;
  logic                    id_hkill;
  logic [HART_ID_B-1:0]    id_set_hid;
  logic                    i_cache_miss;
  logic [HART_ID_B-1:0]    i_miss_hid;
  logic                    i_cache_fin;
  logic                    d_cache_miss;
  logic [HART_ID_B-1:0]    d_miss_hid;
  logic                    d_cache_fin;
  logic [HART_STATE_B-1:0] prim_hstate;
  logic [HART_STATE_B-1:0] acti_hstate;
  logic [HART_STATE_B-1:0] idle_hstate;
  logic                    hstart_err;
  logic                    hkill_err;

  modport master (
    output id_hstart, id_hkill, id_set_hid,
    output i_cache_miss, i_miss_hid, i_cache_fin,
    output d_cache_miss, d_miss_hid, d_cache_fin,
    input  prim_hstate, acti_hstate, idle_hstate,
    input  hstart_err, hkill_err
  );

  modport slave (
    input  id_hstart, id_hkill, id_set_hid,
    input  i_cache_miss, i_miss_hid, i_cache_fin,
    input  d_cache_miss, d_miss_hid, d_cache_fin,
    output prim_hstate, acti_hstate, idle_hstate,
    output hstart_err, hkill_err
  );

endinterface

// File: rtl/hart_state_ctrl_prim_elect.sv
// Primary hart election on the next-state table.
// Keeps a non-idle primary, else cyclic search from prim_hid+1.
module prim_hart_elect
  import hart_state_ctrl_pkg::*;
(
  input  logic [HART_ID_B-1:0]    prim_hid,
  input  logic [HART_STATE_B-1:0] acti_nxt,
  input  logic [HART_STATE_B-1:0] nidle_nxt,
  output logic [HART_STATE_B-1:0] prim_nxt
);

  logic [HART_ID_B-1:0] idx;
  logic [HART_ID_B-1:0] a_hid;
  logic [HART_ID_B-1:0] n_hid;
  logic                 a_fnd;
  logic                 n_fnd;

  // Walk far-to-near so the nearest hit is the last write.
  always_comb begin
    a_fnd = 1'b0;
    n_fnd = 1'b0;
    a_hid = prim_hid;
    n_hid = prim_hid;
    idx   = prim_hid;
    for (int i = HART_NUM - 1; i >= 1; i--) begin
      idx = prim_hid + HART_ID_B'(i);
      if (acti_nxt[idx]) begin
        a_fnd = 1'b1;
        a_hid = idx;
      end
      if (nidle_nxt[idx]) begin
        n_fnd = 1'b1;
        n_hid = idx;
      end
    end
  end

  always_comb begin
    prim_nxt = '0;
    if (nidle_nxt[prim_hid])
      prim_nxt[prim_hid] = 1'b1;
    else if (a_fnd)
      prim_nxt[a_hid] = 1'b1;
    else if (n_fnd)
      prim_nxt[n_hid] = 1'b1;
    else
      prim_nxt[prim_hid] = 1'b1;
  end

endmodule

// File: rtl/hart_state_ctrl.sv
// Hart state table unit: per-hart lifecycle, cache-miss suspend,
// start/kill handling and primary hart tracking.
module hart_state_ctrl
  import hart_state_ctrl_pkg::*;
#(
  parameter logic [HART_ID_B-1:0] PRIM_RST_HID = 2'd0
) (
  input logic              clk,
  input logic              rst,
  hart_state_ctrl_if.slave hs
);

  hart_st_e  st_q [HART_NUM];
  hart_st_e  st_d [HART_NUM];
  miss_own_t i_own_q, i_own_d;
  miss_own_t d_own_q, d_own_d;

  logic [HART_STATE_B-1:0] acti_cur;
  logic [HART_STATE_B-1:0] nidle_cur;
  logic [HART_STATE_B-1:0] acti_d;
  logic [HART_STATE_B-1:0] nidle_d;
  logic [HART_STATE_B-1:0] prim_d;
  logic [HART_ID_B-1:0]    prim_hid;
  logic [2:0]              acti_cnt;
  logic [2:0]              nidle_cnt;
  logic                    i_ok;
  logic                    d_ok;
  logic                    hstart_err_d;
  logic                    hkill_err_d;

  always_comb begin
    for (int h = 0; h < HART_NUM; h++) begin
      acti_cur[h]  = (st_q[h] == HART_ST_ACTIVE);
      nidle_cur[h] = (st_q[h] != HART_ST_IDLE);
      acti_d[h]    = (st_d[h] == HART_ST_ACTIVE);
      nidle_d[h]   = (st_d[h] != HART_ST_IDLE);
    end
  end

  assign acti_cnt  = popcnt4(acti_cur);
  assign nidle_cnt = popcnt4(nidle_cur);

  always_comb begin
    prim_hid = '0;
    unique case (1'b1)
      hs.prim_hstate[1]: prim_hid = 2'd1;
      hs.prim_hstate[2]: prim_hid = 2'd2;
      hs.prim_hstate[3]: prim_hid = 2'd3;
      default:           prim_hid = 2'd0;
    endcase
  end

  // A sole running hart stalls on a miss rather than suspending.
  assign i_ok = hs.i_cache_miss
             && (!i_own_q.valid || hs.i_cache_fin)
             && (acti_cnt >= 3'd2)
             && (st_q[hs.i_miss_hid] == HART_ST_ACTIVE);

  assign d_ok = hs.d_cache_miss
             && (!d_own_q.valid || hs.d_cache_fin)
             && (acti_cnt >= 3'd2)
             && (st_q[hs.d_miss_hid] == HART_ST_ACTIVE);

  always_comb begin
    for (int h = 0; h < HART_NUM; h++)
      st_d[h] = st_q[h];
    i_own_d      = i_own_q;
    d_own_d      = d_own_q;
    hstart_err_d = 1'b0;
    hkill_err_d  = 1'b0;

    if (hs.i_cache_fin && i_own_q.valid) begin
      if (st_q[i_own_q.hid] == HART_ST_WAIT_IC)
        st_d[i_own_q.hid] = HART_ST_ACTIVE;
      i_own_d.valid = 1'b0;
    end
    if (hs.d_cache_fin && d_own_q.valid) begin
      if (st_q[d_own_q.hid] == HART_ST_WAIT_DC)
        st_d[d_own_q.hid] = HART_ST_ACTIVE;
      d_own_d.valid = 1'b0;
    end

    if (i_ok) begin
      st_d[hs.i_miss_hid] = HART_ST_WAIT_IC;
      i_own_d = '{valid: 1'b1, hid: hs.i_miss_hid};
    end
    // Applied after I so WAIT_DC wins on a shared hid.
    if (d_ok) begin
      st_d[hs.d_miss_hid] = HART_ST_WAIT_DC;
      d_own_d = '{valid: 1'b1, hid: hs.d_miss_hid};
    end

    if (hs.id_hkill) begin
      if (st_q[hs.id_set_hid] == HART_ST_IDLE
          || nidle_cnt <= 3'd1)
        hkill_err_d = 1'b1;
      else
        st_d[hs.id_set_hid] = HART_ST_IDLE;
    end else if (hs.id_hstart) begin
      if (st_q[hs.id_set_hid] == HART_ST_IDLE)
        st_d[hs.id_set_hid] = HART_ST_ACTIVE;
      else
        hstart_err_d = 1'b1;
    end
  end

  prim_hart_elect u_elect (
    .prim_hid  (prim_hid),
    .acti_nxt  (acti_d),
    .nidle_nxt (nidle_d),
    .prim_nxt  (prim_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int h = 0; h < HART_NUM; h++)
        st_q[h] <= (HART_ID_B'(h) == PRIM_RST_HID)
                 ? HART_ST_ACTIVE : HART_ST_IDLE;
      i_own_q        <= '0;
      d_own_q        <= '0;
      hs.prim_hstate <= HART_STATE_B'(1) << PRIM_RST_HID;
      hs.acti_hstate <= HART_STATE_B'(1) << PRIM_RST_HID;
      hs.idle_hstate <= ~(HART_STATE_B'(1) << PRIM_RST_HID);
      hs.hstart_err  <= 1'b0;
      hs.hkill_err   <= 1'b0;
    end else begin
      for (int h = 0; h < HART_NUM; h++)
        st_q[h] <= st_d[h];
      i_own_q        <= i_own_d;
      d_own_q        <= d_own_d;
      hs.prim_hstate <= prim_d;
      hs.acti_hstate <= acti_d;
      hs.idle_hstate <= ~nidle_d;
      hs.hstart_err  <= hstart_err_d;
      hs.hkill_err   <= hkill_err_d;
    end
  end

endmodule

// File: tb/tb_hart_state_ctrl.sv
// Directed bench for hart_state_ctrl.
// Observed vector is {prim, acti, idle, hstart_err, hkill_err}.
module tb_hart_state_ctrl;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  hart_state_ctrl_if bus ();

  hart_state_ctrl #(.PRIM_RST_HID(2'd0)) dut (
    .clk (clk),
    .rst (rst),
    .hs  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clr();
    bus.id_hstart    = 1'b0;
    bus.id_hkill     = 1'b0;
    bus.id_set_hid   = 2'd0;
    bus.i_cache_miss = 1'b0;
    bus.i_miss_hid   = 2'd0;
    bus.i_cache_fin  = 1'b0;
    bus.d_cache_miss = 1'b0;
    bus.d_miss_hid   = 2'd0;
    bus.d_cache_fin  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic chk(input string tag, input logic [13:0] exp);
    logic [13:0] obs;
    obs = {bus.prim_hstate, bus.acti_hstate, bus.idle_hstate,
           bus.hstart_err, bus.hkill_err};
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    clr();
    rst = 1'b1;
    #2;
    chk("rst_async", {4'b0001, 4'b0001, 4'b1110, 2'b00});
    rst = 1'b0;
    tick();
    chk("rst_hold", {4'b0001, 4'b0001, 4'b1110, 2'b00});

    bus.id_hstart = 1; bus.id_set_hid = 2'd1; tick();
    chk("start1", {4'b0001, 4'b0011, 4'b1100, 2'b00});
    bus.id_hstart = 1; bus.id_set_hid = 2'd2; tick();
    chk("start2", {4'b0001, 4'b0111, 4'b1000, 2'b00});
    bus.id_hstart = 1; bus.id_set_hid = 2'd1; tick();
    chk("start_err", {4'b0001, 4'b0111, 4'b1000, 2'b10});
    tick();
    chk("err_pulse", {4'b0001, 4'b0111, 4'b1000, 2'b00});
    bus.i_cache_miss = 1; bus.i_miss_hid = 2'd1; tick();
    chk("imiss1", {4'b0001, 4'b0101, 4'b1000, 2'b00});
    bus.i_cache_fin = 1; tick();
    chk("ifin1", {4'b0001, 4'b0111, 4'b1000, 2'b00});

    bus.id_hkill = 1; bus.id_set_hid = 2'd1; tick();
    chk("kill1", {4'b0001, 4'b0101, 4'b1010, 2'b00});
    bus.id_hkill = 1; bus.id_set_hid = 2'd2; tick();
    chk("kill2", {4'b0001, 4'b0001, 4'b1110, 2'b00});
    bus.d_cache_miss = 1; bus.d_miss_hid = 2'd0; tick();
    chk("sole_dmiss", {4'b0001, 4'b0001, 4'b1110, 2'b00});
    bus.d_cache_fin = 1; tick();
    chk("sole_dfin", {4'b0001, 4'b0001, 4'b1110, 2'b00});
    bus.id_hstart = 1; bus.id_set_hid = 2'd1; tick();
    chk("restart1", {4'b0001, 4'b0011, 4'b1100, 2'b00});
    bus.d_cache_miss = 1; bus.d_miss_hid = 2'd1; tick();
    chk("dmiss1_free", {4'b0001, 4'b0001, 4'b1100, 2'b00});
    bus.d_cache_fin = 1; tick();
    chk("dfin1", {4'b0001, 4'b0011, 4'b1100, 2'b00});

    bus.id_hkill = 1; bus.id_set_hid = 2'd0; tick();
    chk("kill_prim0", {4'b0010, 4'b0010, 4'b1101, 2'b00});
    bus.id_hkill = 1; bus.id_set_hid = 2'd1; tick();
    chk("kill_last", {4'b0010, 4'b0010, 4'b1101, 2'b01});
    bus.id_hkill = 1; bus.id_set_hid = 2'd3; tick();
    chk("kill_idle", {4'b0010, 4'b0010, 4'b1101, 2'b01});

    bus.id_hstart = 1; bus.id_set_hid = 2'd0; tick();
    chk("start0", {4'b0010, 4'b0011, 4'b1100, 2'b00});
    bus.id_hstart = 1; bus.id_set_hid = 2'd2; tick();
    chk("start2b", {4'b0010, 4'b0111, 4'b1000, 2'b00});
    bus.i_cache_miss = 1; bus.i_miss_hid = 2'd2;
    bus.d_cache_miss = 1; bus.d_miss_hid = 2'd1; tick();
    chk("dual_miss", {4'b0010, 4'b0001, 4'b1000, 2'b00});
    bus.d_cache_fin = 1; tick();
    chk("dfin_dual", {4'b0010, 4'b0011, 4'b1000, 2'b00});
    bus.id_hkill = 1; bus.id_set_hid = 2'd2; tick();
    chk("kill_wait", {4'b0010, 4'b0011, 4'b1100, 2'b00});
    bus.i_cache_fin = 1; tick();
    chk("ifin_killed", {4'b0010, 4'b0011, 4'b1100, 2'b00});

    bus.id_hstart = 1; bus.id_set_hid = 2'd2; tick();
    chk("start2c", {4'b0010, 4'b0111, 4'b1000, 2'b00});
    bus.i_cache_miss = 1; bus.i_miss_hid = 2'd1; tick();
    chk("imiss_own", {4'b0010, 4'b0101, 4'b1000, 2'b00});
    bus.i_cache_miss = 1; bus.i_miss_hid = 2'd0; tick();
    chk("imiss_busy", {4'b0010, 4'b0101, 4'b1000, 2'b00});
    bus.i_cache_fin = 1;
    bus.i_cache_miss = 1; bus.i_miss_hid = 2'd0; tick();
    chk("fin_and_miss", {4'b0010, 4'b0110, 4'b1000, 2'b00});
    bus.i_cache_fin = 1; tick();
    chk("ifin0", {4'b0010, 4'b0111, 4'b1000, 2'b00});

    bus.d_cache_miss = 1; bus.d_miss_hid = 2'd2; tick();
    chk("dmiss2", {4'b0010, 4'b0011, 4'b1000, 2'b00});
    bus.id_hkill = 1; bus.id_set_hid = 2'd1; tick();
    chk("elect_acti", {4'b0001, 4'b0001, 4'b1010, 2'b00});
    bus.id_hkill = 1; bus.id_set_hid = 2'd0; tick();
    chk("elect_wait", {4'b0100, 4'b0000, 4'b1011, 2'b00});
    bus.d_cache_fin = 1; tick();
    chk("dfin2", {4'b0100, 4'b0100, 4'b1011, 2'b00});
    bus.id_hstart = 1; bus.id_set_hid = 2'd0; tick();
    chk("start0b", {4'b0100, 4'b0101, 4'b1010, 2'b00});
    bus.id_hstart = 1; bus.id_hkill = 1;
    bus.id_set_hid = 2'd0; tick();
    chk("kill_wins", {4'b0100, 4'b0100, 4'b1011, 2'b00});

    bus.id_hstart = 1; bus.id_set_hid = 2'd3; tick();
    chk("start3", {4'b0100, 4'b1100, 4'b0011, 2'b00});
    rst = 1'b1;
    #2;
    chk("rst_mid", {4'b0001, 4'b0001, 4'b1110, 2'b00});
    rst = 1'b0;
    tick();
    chk("rst_after", {4'b0001, 4'b0001, 4'b1110, 2'b00});

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
